pacman_palette_ram: RTL

- Runtime-writable, two-bank colour palette for the Pac-Man renderer, with NUM_RD independent read ports.
- Each read port has a registered output, 1-cycle latency, for the sprite, maze and ghost pixel pipelines.
- Bank 1 is the "frightened flash" palette. It is selected automatically on a frame-based blink while flash_en is high.
- Sits between the sprite/tile index lookups and the VGA colour mux.

---
 rtl/pacman_pkg.sv | 48 ++++
 rtl/pacman_flash_timer.sv | 35 +++
 rtl/pacman_palette_ram.sv | 95 +++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared palette types, the arcade default colours and the reset-image helpers
// for the Pac-Man palette RAM.
package pacman_pkg;

  localparam int unsigned BASE_CH_W = 4;

  typedef struct packed {
    logic [BASE_CH_W-1:0] red;
    logic [BASE_CH_W-1:0] green;
    logic [BASE_CH_W-1:0] blue;
  } rgb_t;

  localparam rgb_t BLACK  = rgb_t'(12'h000);
  localparam rgb_t PINK   = rgb_t'(12'hFBF);
  localparam rgb_t CYAN   = rgb_t'(12'h0AE);
  localparam rgb_t ORANGE = rgb_t'(12'hF71);
  localparam rgb_t BLUE   = rgb_t'(12'h01B);
  localparam rgb_t WHITE  = rgb_t'(12'hFFF);
  localparam rgb_t YELLOW = rgb_t'(12'hFF0);
  localparam rgb_t RED    = rgb_t'(12'hE01);

  function automatic rgb_t default_bank0(input int unsigned i);
    rgb_t c;
    case (i)
      1:       c = PINK;
      2:       c = CYAN;
      3:       c = ORANGE;
      4:       c = BLUE;
      5:       c = WHITE;
      6:       c = YELLOW;
      7:       c = RED;
      default: c = BLACK;
    endcase
    return c;
  endfunction

  // Frightened palette: ghost body and eyes swap blue and white.
  function automatic rgb_t default_bank1(input int unsigned i);
    rgb_t c;
    case (i)
      4:       c = WHITE;
      5:       c = BLUE;
      default: c = default_bank0(i);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pacman_flash_timer.sv
// Frame-based blink timer: toggles flash_phase every FLASH_FRAMES frame ticks
// while flash_en is high; held cleared otherwise.
module pacman_flash_timer #(
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flash_en,
  input  logic frame_tick,
  output logic flash_phase
);

  localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_FRAMES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      flash_phase <= 1'b0;
    end else if (!flash_en) begin
      cnt         <= '0;
      flash_phase <= 1'b0;
    end else if (frame_tick) begin
      if (cnt == CNT_MAX) begin
        cnt         <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pacman_palette_ram.sv
// Two-bank runtime-writable colour palette with NUM_RD registered read ports;
// bank 1 is shown on the blink phase while flash_en is high.
module pacman_palette_ram
  import pacman_pkg::*;
#(
  parameter  int unsigned NUM_ENTRIES  = 16,
  parameter  int unsigned NUM_RD       = 2,
  parameter  int unsigned CH_W         = 4,
  parameter  int unsigned FLASH_FRAMES = 8,
  localparam int unsigned IDX_W        = $clog2(NUM_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*IDX_W-1:0]  rd_index,
  input  logic [NUM_RD-1:0]        rd_valid_in,
  output logic [NUM_RD*CH_W-1:0]   red,
  output logic [NUM_RD*CH_W-1:0]   green,
  output logic [NUM_RD*CH_W-1:0]   blue,
  output logic [NUM_RD-1:0]        rd_valid_out,
  input  logic                     we,
  input  logic                     wbank,
  input  logic [IDX_W-1:0]         waddr,
  input  logic [3*CH_W-1:0]        wdata,
  input  logic                     flash_en,
  input  logic                     frame_tick,
  output logic                     flash_phase
);

  localparam int unsigned COL_W = 3 * CH_W;

  // Default nibbles sit in the top bits of wider channels, rest zero.
  function automatic logic [COL_W-1:0] expand(input rgb_t c);
    logic [CH_W-1:0] r, g, b;
    r = '0;
    g = '0;
    b = '0;
    r[CH_W-1 -: BASE_CH_W] = c.red;
    g[CH_W-1 -: BASE_CH_W] = c.green;
    b[CH_W-1 -: BASE_CH_W] = c.blue;
    return {r, g, b};
  endfunction

  logic [COL_W-1:0]  mem  [2][NUM_ENTRIES];
  logic [COL_W-1:0]  rd_q [NUM_RD];
  logic [NUM_RD-1:0] vld_q;
  logic              sel_c;

  pacman_flash_timer #(
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .flash_en    (flash_en),
    .frame_tick  (frame_tick),
    .flash_phase (flash_phase)
  );

  // Uses the pre-update phase, so a read never sees a phase change mid-cycle.
  assign sel_c = flash_en & flash_phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        mem[0][i] <= expand(default_bank0(i));
        mem[1][i] <= expand(default_bank1(i));
      end
    end else if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  // Read-before-write: a colliding read captures the old entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= mem[sel_c][rd_index[p*IDX_W +: IDX_W]];
      end
      vld_q <= rd_valid_in;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    assign red[p*CH_W +: CH_W]   = rd_q[p][COL_W-1 -: CH_W];
    assign green[p*CH_W +: CH_W] = rd_q[p][2*CH_W-1 -: CH_W];
    assign blue[p*CH_W +: CH_W]  = rd_q[p][CH_W-1:0];
  end

  assign rd_valid_out = vld_q;

endmodule
